uart_tx_fifo: RTL

Synchronous first-word-fall-through FIFO that buffers bytes ahead of the UART transmitter. The writer (host logic or the UART receiver, for loopback) pushes words into it. The transmitter consumes them: `empty` inverted drives the transmitter's `tx_start`, `rd_data` drives its `data_in`, and the transmitter's `tx_done` pulse drives `rd_en`. The head word is presented combinationally, so it is valid whenever `empty` is low.

---
 rtl/uart_tx_fifo.sv | 78 +++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the UART transmitter.
// The head word is shown combinationally; count, empty and full come from one count register.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  ovf_p1;
  logic                  unf_p1;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_COUNT);
  assign count = count_q;

  // A pop on the same edge frees the slot, so a full FIFO still takes the push.
  assign push_ok = wr_en && (!full || rd_en);
  assign pop_ok  = rd_en && !empty;

  assign rd_data   = mem[rd_ptr];
  assign overflow  = ovf_p1;
  assign underflow = unf_p1;

  // Storage: no reset, written only on an accepted push
  always_ff @(posedge clk_100MHz) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and registered rejection flags
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_p1  <= 1'b0;
      unf_p1  <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      ovf_p1 <= wr_en && !push_ok;
      unf_p1 <= rd_en && !pop_ok;
    end
  end

endmodule
